bridge_mem_arbiter: RTL and testbench
=====================================

# bridge_mem_arbiter

Two-port arbiter that shares one fixed-latency memory port between the core (port A, priority) and the APF bridge path (port B, loader writes and unloader reads). Sits in the memory clock domain between the bridge loader/unloader adapters and the core RAM/SDRAM front end. Issues at most one access per cycle, pipelines read returns, and routes each read response back to its owner. A starvation guard keeps bridge save/unload traffic moving while the core is busy.

## Interface
Parameters:
- ADDRESS_SIZE, 28, memory address width
- DATA_WIDTH, 8, memory data width (8 or 16)
- READ_LATENCY, 1, cycles from mem_en (read) to valid mem_rdata; legal range 1..15
- STARVE_LIMIT, 4, consecutive A grants allowed while B waits; must be at least 1

Ports:
- clk_memory  in  1  memory clock; all logic on its rising edge
- reset_n  in  1  asynchronous active-low reset
- a_req  in  1  port A request, held until a_gnt
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  ADDRESS_SIZE  port A address
- a_wdata  in  DATA_WIDTH  port A write data
- a_gnt  out  1  one-cycle pulse: A command issued
- a_rvalid  out  1  one-cycle pulse: a_rdata valid
- a_rdata  out  DATA_WIDTH  A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for port B
- mem_en  out  1  memory command strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDRESS_SIZE  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, READ_LATENCY cycles after read mem_en

## Operation
- Eligibility: a port is eligible when its req=1 and its gnt output is 0 this cycle. A requester must drop req, or present its next command, in the cycle its gnt is high.
- Winner selection:
  - A wins if eligible, unless streak==STARVE_LIMIT and B is eligible, in which case B wins.
  - Otherwise B wins if eligible.
- On a winner, at the next edge:
  - mem_en<=1; mem_we/mem_addr/mem_wdata are loaded from the winner.
  - Winner's gnt<=1.
- With no winner: mem_en<=0, both gnt<=0; mem_addr/mem_wdata hold their values.
- Streak counter, width $clog2(STARVE_LIMIT+1):
  - A granted while B eligible: +1, saturating at STARVE_LIMIT.
  - B granted: cleared.
  - A granted with B not eligible: cleared.
  - No grant: holds.
- Read tracking: shift register of READ_LATENCY+1 stages, each holding {valid, owner}. It captures {mem_en & ~mem_we, owner} every cycle.
- When the stage aligned with valid mem_rdata is valid, at the next edge the owner's rdata<=mem_rdata and the owner's rvalid<=1 for one cycle. The other port's rdata holds.
- Writes produce no response.
- Responses return in issue order; reads from A and B may be interleaved in flight.
- Reset, asynchronous, mid-operation: every output goes to 0, the pipeline and streak are cleared, and in-flight reads are discarded with no rvalid after reset.

## Timing
- Reset values: a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we = 0; mem_addr, mem_wdata, a_rdata, b_rdata = 0.
- Issue: req sampled at edge N yields gnt and mem_en high during cycle N+1.
- Read latency: req at edge N gives rvalid high during cycle N+1+READ_LATENCY+1, i.e. READ_LATENCY+1 cycles after gnt.
- Throughput:
  - One command per cycle overall.
  - A single port gets at most one grant every 2 cycles, because of the gnt-cycle exclusion.
  - With both ports busy, grants alternate back to back with mem_en held continuously high.
- Simultaneous rvalid on both ports never occurs.
- Deasserting req before gnt withdraws the request with no side effects; the streak counter is unchanged.

## Test plan
- Reset: hold reset_n=0 with reqs active -> all outputs 0; release -> first grant one edge later.
- A-only read, READ_LATENCY=2, a_addr=0x10, memory model returns 0x5A -> a_gnt in cycle 1, mem_addr=0x10, a_rvalid in cycle 4 with a_rdata=0x5A; b_rvalid never asserts.
- A and B both requesting continuously, A re-requests immediately, STARVE_LIMIT=4 -> grant sequence A,B,A,B... (A is ineligible in its gnt cycle). With A only blocked by the streak check: after 4 A grants while B waits, B is granted.
- B writes 0x01..0x04 to 0x100..0x103 -> four mem_en pulses with mem_we=1 and correct addr/data; no rvalid on either port.
- Interleaved reads A@0x20, B@0x30, A@0x40, READ_LATENCY=3 -> rvalids arrive in issue order, each on the correct port with the correct data.
- Reset pulse while two reads are in flight -> no rvalid after release; next request served normally.

Source files
------------

// File: rtl/bridge_mem_arbiter.sv
// Shares one fixed-latency memory port between core (A, priority) and bridge (B); gnt one cycle after req, rvalid
// READ_LATENCY+1 cycles after gnt; requesters hold req until gnt, and B is forced through after STARVE_LIMIT A wins.
module bridge_mem_arbiter #(
  parameter int ADDRESS_SIZE = 28,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_memory,
  input  logic                    reset_n,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [ADDRESS_SIZE-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic                    a_gnt,
  output logic                    a_rvalid,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [ADDRESS_SIZE-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic                    b_gnt,
  output logic                    b_rvalid,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  logic                    a_elig, b_elig, a_win, b_win, issue_rd, rsp_vld, rsp_own;
  logic                    a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                    mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]           streak_q, streak_d;
  logic [READ_LATENCY:0]   pipe_vld_q, pipe_vld_d, pipe_own_q, pipe_own_d;
  logic                    a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  // A port is never eligible in its own gnt cycle, so the requester has time to move on.
  always_comb begin
    a_elig = a_req & ~a_gnt_q;
    b_elig = b_req & ~b_gnt_q;
    a_win  = a_elig & ~((streak_q == STREAK_MAX) & b_elig);
    b_win  = b_elig & ~a_win;
  end

  always_comb begin
    a_gnt_d     = a_win;
    b_gnt_d     = b_win;
    mem_en_d    = a_win | b_win;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    streak_d    = streak_q;
    if (a_win) begin
      mem_we_d    = a_we;
      mem_addr_d  = a_addr;
      mem_wdata_d = a_wdata;
      if (!b_elig) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + SW'(1);
      end
    end else if (b_win) begin
      mem_we_d    = b_we;
      mem_addr_d  = b_addr;
      mem_wdata_d = b_wdata;
      streak_d    = '0;
    end
  end

  // Stage 0 is aligned with mem_en; stage READ_LATENCY is aligned with valid mem_rdata.
  always_comb begin
    issue_rd   = (a_win & ~a_we) | (b_win & ~b_we);
    pipe_vld_d = {pipe_vld_q[READ_LATENCY-1:0], issue_rd};
    pipe_own_d = {pipe_own_q[READ_LATENCY-1:0], b_win};
    rsp_vld    = pipe_vld_q[READ_LATENCY];
    rsp_own    = pipe_own_q[READ_LATENCY];
    a_rvalid_d = rsp_vld & ~rsp_own;
    b_rvalid_d = rsp_vld & rsp_own;
    a_rdata_d  = a_rvalid_d ? mem_rdata : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? mem_rdata : b_rdata_q;
  end

  always_ff @(posedge clk_memory or negedge reset_n) begin
    if (!reset_n) begin
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      streak_q    <= '0;
      pipe_vld_q  <= '0;
      pipe_own_q  <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      streak_q    <= streak_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_own_q  <= pipe_own_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_bridge_mem_arbiter.sv
// Randomized bench for bridge_mem_arbiter: requester/arbitration reference model feeds command and
// response queues; a negedge monitor compares every cycle against the queue heads.
module tb_bridge_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 8;
  localparam int RL = 3;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  bridge_mem_arbiter #(.ADDRESS_SIZE(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .STARVE_LIMIT(SL)) dut (
    .clk_memory(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          due;
    bit          port;
    bit          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } cmd_t;

  typedef struct {
    int          due;
    bit          port;
    logic [DW-1:0] data;
  } rsp_t;

  cmd_t cmdq[$];
  rsp_t rspq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   b_starve_wins = 0;

  // Requester and reference state
  bit          pend[2];
  bit          c_we[2];
  logic [AW-1:0] c_addr[2];
  logic [DW-1:0] c_wd[2];
  bit          m_gnt[2];
  int          streak;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_addr_wd;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_rd[2];

  // Memory model state (driven only by what the DUT actually issues)
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  logic [DW-1:0] rdq [int];

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_clear();
    cmdq.delete();
    rspq.delete();
    streak = 0;
    for (int p = 0; p < 2; p++) begin
      m_gnt[p]  = 1'b0;
      pend[p]   = 1'b0;
      exp_rd[p] = '0;
    end
    exp_addr    = '0;
    exp_addr_wd = '0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: read data is presented RL cycles after the mem_en cycle, garbage otherwise.
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) mem_arr[mem_addr] = mem_wdata;
      else rdq[cyc + RL] = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : dflt(mem_addr);
    end
    if (rdq.exists(cyc)) begin
      mem_rdata = rdq[cyc];
      rdq.delete(cyc);
    end else begin
      mem_rdata = 8'($urandom);
    end
  end

  // Monitor
  always @(negedge clk) begin
    cmd_t c;
    rsp_t r;
    if (reset_n === 1'b0) begin
      chk("rst_ctl", {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we}, 0);
      chk("rst_data", {mem_addr, mem_wdata, a_rdata, b_rdata}, 0);
    end else begin
      if (cmdq.size() > 0 && cmdq[0].due == cyc) begin
        c = cmdq.pop_front();
        chk("cmd_en", mem_en, 1);
        chk("cmd_gnt", {a_gnt, b_gnt}, c.port ? 2'b01 : 2'b10);
        chk("cmd_we", mem_we, c.we);
        chk("cmd_addr", mem_addr, c.addr);
        chk("cmd_wdata", mem_wdata, c.wd);
        exp_addr    = c.addr;
        exp_addr_wd = c.wd;
      end else begin
        chk("idle_ctl", {mem_en, a_gnt, b_gnt}, 0);
        chk("idle_hold", {mem_addr, mem_wdata}, {exp_addr, exp_addr_wd});
      end
      if (rspq.size() > 0 && rspq[0].due == cyc) begin
        r = rspq.pop_front();
        exp_rd[r.port] = r.data;
        chk("rsp_valid", {a_rvalid, b_rvalid}, r.port ? 2'b01 : 2'b10);
      end else begin
        chk("no_rsp", {a_rvalid, b_rvalid}, 0);
      end
      chk("a_rdata", a_rdata, exp_rd[0]);
      chk("b_rdata", b_rdata, exp_rd[1]);
    end
  end

  // One requester/arbitration decision for the coming edge, made half a cycle before it.
  task automatic body(input int pa, input int pb, input int wpa, input int wpb, input int wdr, input bit shy);
    bit rq[2];
    bit el[2];
    int prob[2];
    int wp[2];
    int win;
    cmd_t c;
    rsp_t r;
    prob[0] = pa; prob[1] = pb; wp[0] = wpa; wp[1] = wpb;
    for (int p = 0; p < 2; p++) begin
      if (m_gnt[p]) pend[p] = 1'b0;
      if (!pend[p] && int'($urandom_range(99)) < prob[p]) begin
        pend[p]   = 1'b1;
        c_we[p]   = int'($urandom_range(99)) < wp[p];
        c_addr[p] = AW'($urandom_range(63)) + (p == 1 && wp[p] == 100 ? 28'h100 : 28'h0);
        c_wd[p]   = 8'($urandom);
      end
      rq[p] = pend[p];
      if (pend[p] && !m_gnt[p] && int'($urandom_range(99)) < wdr) rq[p] = 1'b0;
    end
    if (shy && m_gnt[0]) rq[1] = 1'b0;
    a_req = rq[0]; a_we = c_we[0]; a_addr = c_addr[0]; a_wdata = c_wd[0];
    b_req = rq[1]; b_we = c_we[1]; b_addr = c_addr[1]; b_wdata = c_wd[1];

    el[0] = rq[0] && !m_gnt[0];
    el[1] = rq[1] && !m_gnt[1];
    win = -1;
    if (el[0] && !(streak == SL && el[1])) win = 0;
    else if (el[1]) win = 1;
    if (win == 1 && el[0]) b_starve_wins++;
    if (win == 0) streak = el[1] ? (streak < SL ? streak + 1 : streak) : 0;
    else if (win == 1) streak = 0;
    m_gnt[0] = (win == 0);
    m_gnt[1] = (win == 1);
    if (win >= 0) begin
      c.due = cyc + 1; c.port = win[0]; c.we = c_we[win];
      c.addr = c_addr[win]; c.wd = c_wd[win];
      cmdq.push_back(c);
      if (c.we) begin
        ref_mem[c.addr] = c.wd;
      end else begin
        r.due  = cyc + 2 + RL;
        r.port = c.port;
        r.data = ref_mem.exists(c.addr) ? ref_mem[c.addr] : dflt(c.addr);
        rspq.push_back(r);
      end
    end
  endtask

  task automatic run(input int n, input int pa, input int pb, input int wpa, input int wpb,
                     input int wdr, input bit shy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      body(pa, pb, wpa, wpb, wdr, shy);
    end
  endtask

  // Reset with both requests active; on release both ports have a command waiting.
  task automatic reset_cycle(input int ncyc);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    model_clear();
    a_req = 1'b1; b_req = 1'b1;
    repeat (ncyc) @(negedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b1;
      c_we[p] = p[0];
      c_addr[p] = AW'(32 + p);
      c_wd[p] = 8'(p + 8'h11);
    end
    reset_n = 1'b1;
    body(0, 0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b1;
    mem_rdata = '0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    model_clear();
    #1 reset_n = 1'b0;
    reset_cycle(4);
    run(400, 60, 60, 40, 40, 5, 1'b0);   // mixed traffic
    run(100, 70, 0, 0, 0, 5, 1'b0);      // A-only reads
    run(100, 0, 80, 0, 100, 0, 1'b0);    // B-only writes
    run(200, 100, 100, 30, 30, 0, 1'b0); // both saturated: alternation
    run(200, 100, 100, 30, 30, 0, 1'b1); // B waits only while A eligible: starvation guard
    run(60, 80, 80, 20, 20, 0, 1'b0);
    reset_cycle(3);                      // reset with reads in flight
    run(150, 60, 60, 40, 40, 5, 1'b0);
    run(RL + 12, 0, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    a_req = 1'b0; b_req = 1'b0;
    repeat (RL + 4) @(negedge clk);
    #2;
    chk("cmdq_drained", cmdq.size(), 0);
    chk("rspq_drained", rspq.size(), 0);
    chk("starve_guard_hit", b_starve_wins > 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
